// File: rtl/sound_pkg.sv
// Shared definitions for the sound sequencer: tone codes, event priorities,
// pattern ROM constants and FSM state encoding.
package sound_pkg;

    typedef enum logic [1:0] {
        TONE_MID  = 2'd0,
        TONE_LOW  = 2'd1,
        TONE_HIGH = 2'd2,
        TONE_REST = 2'd3
    } tone_t;

    // Numeric order is the priority order, so a plain compare decides preemption.
    typedef enum logic [1:0] {
        PAT_NONE  = 2'd0,
        PAT_HIT   = 2'd1,
        PAT_POINT = 2'd2,
        PAT_OVER  = 2'd3
    } pat_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    localparam logic [2:0] HIT_STEPS   = 3'd1;
    localparam logic [2:0] POINT_STEPS = 3'd2;
    localparam logic [2:0] OVER_STEPS  = 3'd5;

    localparam logic [5:0] HIT_T0   = 6'd5;
    localparam logic [5:0] POINT_T0 = 6'd10;
    localparam logic [5:0] POINT_T1 = 6'd10;
    localparam logic [5:0] OVER_T0  = 6'd20;
    localparam logic [5:0] OVER_T1  = 6'd20;
    localparam logic [5:0] OVER_T2  = 6'd40;
    localparam logic [5:0] OVER_T3  = 6'd10;
    localparam logic [5:0] OVER_T4  = 6'd40;

    function automatic logic [2:0] last_step(pat_t p);
        case (p)
            PAT_HIT:   return HIT_STEPS - 3'd1;
            PAT_POINT: return POINT_STEPS - 3'd1;
            PAT_OVER:  return OVER_STEPS - 3'd1;
            default:   return 3'd0;
        endcase
    endfunction

    function automatic pat_t event_pri(logic hit, logic point, logic over);
        if (over)       return PAT_OVER;
        else if (point) return PAT_POINT;
        else if (hit)   return PAT_HIT;
        else            return PAT_NONE;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks, restartable.
module tick_prescaler #(
    parameter int TICK_DIV = 500000
) (
    input  logic clk,
    input  logic hush,
    input  logic restart,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge hush) begin
        if (!hush)
            cnt <= '0;
        else if (restart || cnt == CNT_LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/sound_sequencer.sv
// Event-driven tone sequencer feeding the speaker tone generator.
// state   | meaning
// IDLE    | silent, waiting for an event
// PLAY    | stepping through the current pattern
module sound_sequencer
    import sound_pkg::*;
#(
    parameter int TICK_DIV = 500000
) (
    input  logic clk,
    input  logic hush,
    input  logic ev_hit,
    input  logic ev_point,
    input  logic ev_over,
    output logic sw1,
    output logic sw2,
    output logic tone_hush,
    output logic busy
);

    state_t     state;
    pat_t       cur_pat, ev_pri, nxt_pat;
    logic [2:0] step, nxt_step;
    logic [5:0] dur;
    logic       tick, expire, is_last, accept, load;
    tone_t      rom_tone;
    logic [5:0] rom_ticks;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk     (clk),
        .hush    (hush),
        .restart (load),
        .tick    (tick)
    );

    always_comb begin
        ev_pri   = event_pri(ev_hit, ev_point, ev_over);
        is_last  = (step == last_step(cur_pat));
        expire   = (state == ST_PLAY) && tick && (dur == 6'd1);
        // An event landing on the final expiry edge chains straight into a new pattern.
        accept   = (ev_pri != PAT_NONE) &&
                   ((state == ST_IDLE) || (ev_pri > cur_pat) || (expire && is_last));
        load     = accept || (expire && !is_last);
        nxt_pat  = accept ? ev_pri : cur_pat;
        nxt_step = accept ? 3'd0 : step + 3'd1;

        rom_tone  = TONE_REST;
        rom_ticks = 6'd0;
        case ({nxt_pat, nxt_step})
            {PAT_HIT,   3'd0}: begin rom_tone = TONE_HIGH; rom_ticks = HIT_T0;   end
            {PAT_POINT, 3'd0}: begin rom_tone = TONE_MID;  rom_ticks = POINT_T0; end
            {PAT_POINT, 3'd1}: begin rom_tone = TONE_HIGH; rom_ticks = POINT_T1; end
            {PAT_OVER,  3'd0}: begin rom_tone = TONE_HIGH; rom_ticks = OVER_T0;  end
            {PAT_OVER,  3'd1}: begin rom_tone = TONE_MID;  rom_ticks = OVER_T1;  end
            {PAT_OVER,  3'd2}: begin rom_tone = TONE_LOW;  rom_ticks = OVER_T2;  end
            {PAT_OVER,  3'd3}: begin rom_tone = TONE_REST; rom_ticks = OVER_T3;  end
            {PAT_OVER,  3'd4}: begin rom_tone = TONE_LOW;  rom_ticks = OVER_T4;  end
            default:           begin rom_tone = TONE_REST; rom_ticks = 6'd0;     end
        endcase
    end

    always_ff @(posedge clk or negedge hush) begin
        if (!hush) begin
            state     <= ST_IDLE;
            cur_pat   <= PAT_NONE;
            step      <= 3'd0;
            dur       <= 6'd0;
            sw1       <= 1'b0;
            sw2       <= 1'b0;
            tone_hush <= 1'b0;
            busy      <= 1'b0;
        end else if (load) begin
            state     <= ST_PLAY;
            cur_pat   <= nxt_pat;
            step      <= nxt_step;
            dur       <= rom_ticks;
            sw1       <= (rom_tone == TONE_LOW);
            sw2       <= (rom_tone == TONE_HIGH);
            tone_hush <= (rom_tone != TONE_REST);
            busy      <= 1'b1;
        end else if (expire) begin
            state     <= ST_IDLE;
            cur_pat   <= PAT_NONE;
            step      <= 3'd0;
            dur       <= 6'd0;
            sw1       <= 1'b0;
            sw2       <= 1'b0;
            tone_hush <= 1'b0;
            busy      <= 1'b0;
        end else if (state == ST_PLAY && tick) begin
            dur <= dur - 6'd1;
        end
    end

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer with TICK_DIV=4 (one tick = 4 clocks).
module tb_sound_sequencer;

    logic clk = 1'b0;
    logic hush, ev_hit, ev_point, ev_over;
    logic sw1, sw2, tone_hush, busy;

    int n_cmp = 0;
    int n_bad = 0;

    // {sw1, sw2, tone_hush, busy}
    localparam logic [3:0] O_IDLE = 4'b0000;
    localparam logic [3:0] O_HIGH = 4'b0111;
    localparam logic [3:0] O_MID  = 4'b0011;
    localparam logic [3:0] O_LOW  = 4'b1011;
    localparam logic [3:0] O_REST = 4'b0001;

    sound_sequencer #(.TICK_DIV(4)) dut (
        .clk       (clk),
        .hush      (hush),
        .ev_hit    (ev_hit),
        .ev_point  (ev_point),
        .ev_over   (ev_over),
        .sw1       (sw1),
        .sw2       (sw2),
        .tone_hush (tone_hush),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Checks n consecutive negedge samples, starting at the current one.
    task automatic expect_run(input string tag, input logic [3:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            assert ({sw1, sw2, tone_hush, busy} === exp) else begin
                n_bad++;
                $error("FAIL %s sample %0d: got %b expected %b", tag, i,
                       {sw1, sw2, tone_hush, busy}, exp);
            end
            n_cmp++;
            assert (!(sw1 && sw2)) else begin
                n_bad++;
                $error("FAIL %s_excl sample %0d: got sw1&sw2=%b expected 0", tag, i, sw1 & sw2);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        hush = 1'b0; ev_hit = 1'b0; ev_point = 1'b0; ev_over = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            ev_hit = i[0]; ev_point = i[1]; ev_over = i[2];
            expect_run("in_reset", O_IDLE, 1);
        end
        ev_hit = 1'b0; ev_point = 1'b0; ev_over = 1'b0;
        hush = 1'b1;
        expect_run("after_reset", O_IDLE, 10);

        // hit: 20 cycles HIGH; self-retrigger ignored; event on expiry edge chains
        ev_hit = 1'b1; @(negedge clk); ev_hit = 1'b0;
        expect_run("hit_a", O_HIGH, 4);
        ev_hit = 1'b1; expect_run("hit_retrig", O_HIGH, 1); ev_hit = 1'b0;
        expect_run("hit_b", O_HIGH, 14);
        ev_hit = 1'b1; expect_run("hit_last", O_HIGH, 1); ev_hit = 1'b0;
        expect_run("hit_chain", O_HIGH, 20);
        expect_run("hit_done", O_IDLE, 3);

        // point: MID 40 then HIGH 40 with no gap
        ev_point = 1'b1; @(negedge clk); ev_point = 1'b0;
        expect_run("point_mid", O_MID, 40);
        expect_run("point_high", O_HIGH, 40);
        expect_run("point_done", O_IDLE, 2);

        // all three together: over wins; point mid-over ignored
        ev_hit = 1'b1; ev_point = 1'b1; ev_over = 1'b1; @(negedge clk);
        ev_hit = 1'b0; ev_point = 1'b0; ev_over = 1'b0;
        expect_run("over_high_a", O_HIGH, 10);
        ev_point = 1'b1; expect_run("over_pt_ign", O_HIGH, 1); ev_point = 1'b0;
        expect_run("over_high_b", O_HIGH, 69);
        expect_run("over_mid", O_MID, 80);
        expect_run("over_low1", O_LOW, 160);
        expect_run("over_rest", O_REST, 40);
        expect_run("over_low2", O_LOW, 160);
        expect_run("over_done", O_IDLE, 2);

        // over preempts point after 10 cycles
        ev_point = 1'b1; @(negedge clk); ev_point = 1'b0;
        expect_run("pre_mid", O_MID, 10);
        ev_over = 1'b1; expect_run("pre_edge", O_MID, 1); ev_over = 1'b0;
        expect_run("pre_high", O_HIGH, 80);
        expect_run("pre_mid2", O_MID, 80);
        expect_run("pre_low1", O_LOW, 160);
        expect_run("pre_rest", O_REST, 15);

        // asynchronous reset during REST
        hush = 1'b0;
        #1;
        n_cmp++;
        assert ({sw1, sw2, tone_hush, busy} === O_IDLE) else begin
            n_bad++;
            $error("FAIL async_reset: got %b expected %b", {sw1, sw2, tone_hush, busy}, O_IDLE);
        end
        @(negedge clk);
        hush = 1'b1;
        expect_run("no_resume", O_IDLE, 40);

        ev_hit = 1'b1; @(negedge clk); ev_hit = 1'b0;
        expect_run("hit_post", O_HIGH, 20);
        expect_run("hit_post_done", O_IDLE, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
